// File: rtl/mem_copy.sv
// Streaming word copier: reads a source range and writes it to a destination
// through the shared memory request/response FIFOs, bounded by a credit window.
module mem_copy #(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [21:0] src_addr,
   input  logic [21:0] dst_addr,
   input  logic [21:0] word_count,
   output logic        busy,
   output logic        done,
   output logic [1:0]  mem_req_wr_cmd,
   output logic [21:0] mem_req_wr_addr,
   output logic [63:0] mem_req_wr_dta,
   output logic        mem_req_wr_en,
   input  logic        mem_req_wr_almost_full,
   input  logic [63:0] mem_res_rd_dta,
   output logic        mem_res_rd_en,
   input  logic        mem_res_rd_valid
);

   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t      state_q, state_n;
   logic [21:0] rd_ptr_q, rd_ptr_n;
   logic [21:0] wr_ptr_q, wr_ptr_n;
   logic [21:0] cnt_q, cnt_n;
   logic [21:0] rd_iss_q, rd_iss_n;
   logic [21:0] wr_iss_q, wr_iss_n;
   logic [AW-1:0] head_q, head_n;
   logic [AW-1:0] tail_q, tail_n;
   logic [AW:0] fill_q, fill_n;
   logic        busy_n, done_n, en_n, rd_en_n;
   logic [1:0]  cmd_n;
   logic [21:0] addr_n;
   logic [63:0] dta_n;
   logic        push, pop, credit_ok;

   logic [63:0] buf_mem [MAX_OUTSTANDING];

   // credits cover reads still in flight, so the buffer can never overflow
   assign credit_ok = (rd_iss_q - wr_iss_q) < 22'(MAX_OUTSTANDING);

   always_comb begin
      state_n  = state_q;
      rd_ptr_n = rd_ptr_q;
      wr_ptr_n = wr_ptr_q;
      cnt_n    = cnt_q;
      rd_iss_n = rd_iss_q;
      wr_iss_n = wr_iss_q;
      head_n   = head_q;
      tail_n   = tail_q;
      busy_n   = busy;
      done_n   = 1'b0;
      en_n     = 1'b0;
      cmd_n    = mem_req_wr_cmd;
      addr_n   = mem_req_wr_addr;
      dta_n    = mem_req_wr_dta;
      push     = 1'b0;
      pop      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rd_ptr_n = src_addr;
               wr_ptr_n = dst_addr;
               cnt_n    = word_count;
               rd_iss_n = '0;
               wr_iss_n = '0;
               busy_n   = 1'b1;
               state_n  = (word_count == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            push = mem_res_rd_valid;
            if (!mem_req_wr_almost_full) begin
               if (fill_q != '0) begin
                  en_n     = 1'b1;
                  cmd_n    = CMD_WRITE;
                  addr_n   = wr_ptr_q;
                  dta_n    = buf_mem[head_q];
                  pop      = 1'b1;
                  wr_ptr_n = wr_ptr_q + 22'd1;
                  wr_iss_n = wr_iss_q + 22'd1;
                  if (wr_iss_n == cnt_q) state_n = FINISH;
               end else if (rd_iss_q != cnt_q && credit_ok) begin
                  en_n     = 1'b1;
                  cmd_n    = CMD_READ;
                  addr_n   = rd_ptr_q;
                  dta_n    = '0;
                  rd_ptr_n = rd_ptr_q + 22'd1;
                  rd_iss_n = rd_iss_q + 22'd1;
               end
            end
         end
         FINISH: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (pop)  head_n = head_q + AW'(1);
      if (push) tail_n = tail_q + AW'(1);
      fill_n  = fill_q + (AW+1)'(push) - (AW+1)'(pop);
      rd_en_n = (state_n == RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         cnt_q           <= '0;
         rd_iss_q        <= '0;
         wr_iss_q        <= '0;
         head_q          <= '0;
         tail_q          <= '0;
         fill_q          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mem_req_wr_en   <= 1'b0;
         mem_req_wr_cmd  <= '0;
         mem_req_wr_addr <= '0;
         mem_req_wr_dta  <= '0;
         mem_res_rd_en   <= 1'b0;
      end else begin
         state_q         <= state_n;
         rd_ptr_q        <= rd_ptr_n;
         wr_ptr_q        <= wr_ptr_n;
         cnt_q           <= cnt_n;
         rd_iss_q        <= rd_iss_n;
         wr_iss_q        <= wr_iss_n;
         head_q          <= head_n;
         tail_q          <= tail_n;
         fill_q          <= fill_n;
         busy            <= busy_n;
         done            <= done_n;
         mem_req_wr_en   <= en_n;
         mem_req_wr_cmd  <= cmd_n;
         mem_req_wr_addr <= addr_n;
         mem_req_wr_dta  <= dta_n;
         mem_res_rd_en   <= rd_en_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_mem[tail_q] <= mem_res_rd_dta;
   end

endmodule
